dmr_tmr_reg_ctrl: RTL and testbench

Control FSM for a bank of DMR-input / TMR-state registers (`dmr_io_tmr_reg` instances sharing one `no_load_i`). It gates loads on DMR mismatch and holds the upstream handshake for bounded retries. On a voter mismatch it schedules a scrub, writing the voted value back into all three copies, and checks the result the next cycle. It escalates to a sticky fatal state on persistent faults. It sits between the upstream producer's valid/ready handshake and the register bank's `no_load_i` and data-input mux.

---
 rtl/dmr_tmr_reg_ctrl_if.sv | 21 ++
 rtl/dmr_tmr_reg_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmr_tmr_reg_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmr_tmr_reg_ctrl_if.sv
// Handshake and register-bank control signals between the upstream producer,
// the DMR/TMR register bank and dmr_tmr_reg_ctrl.
interface dmr_tmr_reg_ctrl_if;
  logic valid_i;
  logic dmr_err_i;
  logic voter_err_i;
  logic ready_o;
  logic no_load_o;
  logic scrub_o;

  // The controller side receives upstream/bank status and drives the bank controls.
  modport slave (
    input  valid_i, dmr_err_i, voter_err_i,
    output ready_o, no_load_o, scrub_o
  );

  modport master (
    output valid_i, dmr_err_i, voter_err_i,
    input  ready_o, no_load_o, scrub_o
  );
endinterface

// File: rtl/dmr_tmr_reg_ctrl.sv
// Load-gating, retry, scrub and fatal-escalation controller for a bank of
// DMR-input / TMR-state registers sharing one no_load_i.
module dmr_tmr_reg_ctrl #(
  parameter int unsigned MaxRetries = 3,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dmr_tmr_reg_ctrl_if.slave   ctrl,
  input  logic                clear_i,
  output logic                stall_o,
  output logic                fatal_o,
  output logic [CntWidth-1:0] dmr_err_cnt_o,
  output logic [CntWidth-1:0] voter_err_cnt_o
);

  localparam int unsigned RetryW = (MaxRetries > 1) ? $clog2(MaxRetries) : 1;
  localparam logic [RetryW-1:0] RetryLast = RetryW'(MaxRetries - 1);

  typedef enum logic [2:0] {
    Run,
    Retry,
    Scrub,
    Verify,
    Fatal
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [CntWidth-1:0] dmr_cnt_q, dmr_cnt_d;
  logic [CntWidth-1:0] vot_cnt_q, vot_cnt_d;
  logic                stall_q, fatal_q;

  logic valid, dmr_err, voter_err;
  logic transfer, scrubbing;
  logic inc_dmr, inc_vot;

  assign valid     = ctrl.valid_i;
  assign dmr_err   = ctrl.dmr_err_i;
  assign voter_err = ctrl.voter_err_i;

  // Load decision is combinational so the bank captures in the same cycle.
  assign transfer  = valid & ~dmr_err & ((state_q == Run) | (state_q == Retry));
  assign scrubbing = (state_q == Scrub);

  assign ctrl.ready_o   = transfer;
  assign ctrl.scrub_o   = scrubbing;
  assign ctrl.no_load_o = ~(transfer | scrubbing);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    retry_d = retry_q;
    inc_dmr = 1'b0;
    inc_vot = 1'b0;

    unique case (state_q)
      Run: begin
        if (transfer) begin
          // A load rewrites all three copies, so a concurrent voter error needs no scrub.
          inc_vot = voter_err;
        end else if (voter_err) begin
          inc_vot = 1'b1;
          inc_dmr = valid & dmr_err;
          ret_d   = Run;
          state_d = Scrub;
        end else if (valid & dmr_err) begin
          inc_dmr = 1'b1;
          retry_d = '0;
          state_d = Retry;
        end
      end

      Retry: begin
        if (transfer) begin
          inc_vot = voter_err;
          state_d = Run;
        end else if (voter_err) begin
          inc_vot = 1'b1;
          inc_dmr = valid & dmr_err;
          ret_d   = Retry;
          state_d = Scrub;
        end else if (valid & dmr_err) begin
          inc_dmr = 1'b1;
          if (retry_q == RetryLast) begin
            state_d = Fatal;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end

      Scrub: begin
        state_d = Verify;
      end

      Verify: begin
        if (voter_err) begin
          inc_vot = 1'b1;
          state_d = Fatal;
        end else begin
          state_d = ret_q;
        end
      end

      Fatal: begin
        if (clear_i) begin
          retry_d = '0;
          state_d = Run;
        end
      end

      default: begin
        state_d = Run;
      end
    endcase

    if (clear_i) begin
      dmr_cnt_d = '0;
      vot_cnt_d = '0;
    end else begin
      dmr_cnt_d = (inc_dmr && (dmr_cnt_q != '1)) ? dmr_cnt_q + 1'b1 : dmr_cnt_q;
      vot_cnt_d = (inc_vot && (vot_cnt_q != '1)) ? vot_cnt_q + 1'b1 : vot_cnt_q;
    end
  end

  // stall/fatal are registered from the next state, i.e. a pure decode of state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Run;
      ret_q     <= Run;
      retry_q   <= '0;
      dmr_cnt_q <= '0;
      vot_cnt_q <= '0;
      stall_q   <= 1'b0;
      fatal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      retry_q   <= retry_d;
      dmr_cnt_q <= dmr_cnt_d;
      vot_cnt_q <= vot_cnt_d;
      stall_q   <= (state_d != Run);
      fatal_q   <= (state_d == Fatal);
    end
  end

  assign stall_o         = stall_q;
  assign fatal_o         = fatal_q;
  assign dmr_err_cnt_o   = dmr_cnt_q;
  assign voter_err_cnt_o = vot_cnt_q;

endmodule

// File: tb/tb_dmr_tmr_reg_ctrl.sv
// Scoreboard bench for dmr_tmr_reg_ctrl: directed scenarios followed by
// randomized traffic against a behavioural model of the controller.
module tb_dmr_tmr_reg_ctrl;

  localparam int MAXR   = 3;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          stall, fatal;
  logic [CW-1:0] dcnt_o, vcnt_o;

  dmr_tmr_reg_ctrl_if bus ();

  dmr_tmr_reg_ctrl #(.MaxRetries(MAXR), .CntWidth(CW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ctrl           (bus),
    .clear_i        (clear),
    .stall_o        (stall),
    .fatal_o        (fatal),
    .dmr_err_cnt_o  (dcnt_o),
    .voter_err_cnt_o(vcnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ready;
    int no_load;
    int scrub;
    int stall;
    int fatal;
    int dc;
    int vc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 0;

  // Behavioural model: mode names, retries spent, and the mode to resume after a scrub.
  string m_mode = "RUN";
  string m_back = "RUN";
  int    m_tries = 0;
  int    m_dc = 0;
  int    m_vc = 0;

  task automatic model_step(input bit v, input bit d, input bit vo, input bit clr, input bit rst);
    exp_t e;
    bit   acc, id, iv;
    if (rst) begin
      m_mode = "RUN"; m_back = "RUN"; m_tries = 0; m_dc = 0; m_vc = 0;
    end
    acc       = ((m_mode == "RUN") || (m_mode == "RETRY")) && v && !d;
    e.ready   = int'(acc);
    e.scrub   = int'(m_mode == "SCRUB");
    e.no_load = int'(!(acc || (m_mode == "SCRUB")));
    e.stall   = int'(m_mode != "RUN");
    e.fatal   = int'(m_mode == "FATAL");
    e.dc      = m_dc;
    e.vc      = m_vc;
    q.push_back(e);
    if (rst) return;
    id = 0; iv = 0;
    if (m_mode == "RUN" || m_mode == "RETRY") begin
      if (acc) begin
        iv = vo;
        m_mode = "RUN";
      end else if (vo) begin
        iv = 1; id = v && d;
        m_back = m_mode;
        m_mode = "SCRUB";
      end else if (v && d) begin
        id = 1;
        if (m_mode == "RUN") begin
          m_mode = "RETRY"; m_tries = 0;
        end else if (m_tries + 1 >= MAXR) begin
          m_mode = "FATAL";
        end else begin
          m_tries++;
        end
      end
    end else if (m_mode == "SCRUB") begin
      m_mode = "VERIFY";
    end else if (m_mode == "VERIFY") begin
      if (vo) begin
        iv = 1; m_mode = "FATAL";
      end else begin
        m_mode = m_back;
      end
    end else if (m_mode == "FATAL" && clr) begin
      m_mode = "RUN"; m_tries = 0;
    end
    if (clr) begin
      m_dc = 0; m_vc = 0;
    end else begin
      if (id && m_dc < CNTMAX) m_dc++;
      if (iv && m_vc < CNTMAX) m_vc++;
    end
  endtask

  task automatic cyc(input bit v, input bit d, input bit vo, input bit clr, input bit rst);
    @(negedge clk);
    rst_n           = !rst;
    bus.valid_i     = v;
    bus.dmr_err_i   = d;
    bus.voter_err_i = vo;
    clear           = clr;
    #1;
    model_step(v, d, vo, clr, rst);
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Monitor: pops one expected record per cycle and compares every output.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready_o",         int'(bus.ready_o   === 1'b1), e.ready);
        chk("no_load_o",       int'(bus.no_load_o === 1'b1), e.no_load);
        chk("scrub_o",         int'(bus.scrub_o   === 1'b1), e.scrub);
        chk("stall_o",         int'(stall === 1'b1),         e.stall);
        chk("fatal_o",         int'(fatal === 1'b1),         e.fatal);
        chk("dmr_err_cnt_o",   (^dcnt_o === 1'bx) ? -1 : int'(dcnt_o), e.dc);
        chk("voter_err_cnt_o", (^vcnt_o === 1'bx) ? -1 : int'(vcnt_o), e.vc);
      end
    end
  end

  initial begin
    bus.valid_i = 0; bus.dmr_err_i = 0; bus.voter_err_i = 0;
    // Reset values, including a combinational transfer while still in reset.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // Clean stream of 8 beats.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
    // Two DMR mismatches then acceptance.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Persistent DMR mismatch escalates to FATAL, which is sticky until clear.
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // Single voter pulse on an idle bank: scrub, clean verify, back to run.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    // Stuck voter error: scrub, verify fails, fatal.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // Voter error in RETRY with counter 1; retry counter must survive the scrub.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // Asynchronous reset in FATAL, then in RETRY.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // Counter saturation, then a clear in RUN.
    for (int i = 0; i < CNTMAX + 4; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end
    @(negedge clk);
    #3;
    done = 1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
